bank_sched: RTL

BANK_SCHED -- requirements
Module: bank_sched

---
 rtl/bank_sched_pkg.sv | 21 ++
 rtl/raster_ctr.sv | 51 +++++
 rtl/bank_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bank_sched_pkg.sv
// Shared types and constants for the ping-pong frame buffer scheduler.
package bank_sched_pkg;

  localparam int unsigned DIM_DEF = 5;
  localparam int unsigned W_DEF   = 64;
  localparam int unsigned LAST    = DIM_DEF - 1;
  localparam int unsigned COORD_W = 3;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // A bank holding a complete frame cannot accept writes.
  function automatic logic bank_busy(bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/raster_ctr.sv
// Raster-order (x,y) lane counter with clear, advance, hold and last-lane flag.
module raster_ctr
  import bank_sched_pkg::*;
#(
  parameter int unsigned LAST_IDX = LAST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // Next position: clear wins over advance; x wraps into the next row.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_q == COORD_W'(LAST_IDX)) begin
        x_d = '0;
        y_d = (y_q == COORD_W'(LAST_IDX)) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == COORD_W'(LAST_IDX)) && (y_q == COORD_W'(LAST_IDX));

endmodule

// File: rtl/bank_sched.sv
// Two-bank ping-pong scheduler: raster-writes incoming frames, drains them in arrival order.
module bank_sched
  import bank_sched_pkg::*;
#(
  parameter int unsigned DIM = DIM_DEF,
  parameter int unsigned W   = W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pushin,
  input  logic               firstin,
  input  logic [W-1:0]       din,
  output logic               stopin,
  output logic               wr,
  output logic               wbank,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic [W-1:0]       wd,
  output logic               rbank,
  output logic [COORD_W-1:0] rx,
  output logic [COORD_W-1:0] ry,
  output logic               pushout,
  output logic               firstout,
  input  logic               stopout
);

  localparam int unsigned LAST_IDX = DIM - 1;

  bank_state_e bank_q [0:1];
  bank_state_e bank_d [0:1];
  logic        wp_q, wp_d;
  logic        rp_q, rp_d;
  logic        wr_q, wr_d;
  logic        wbank_q, wbank_d;
  logic [W-1:0] wd_q;
  logic        po_q, po_d;
  logic        fo_q, fo_d;
  logic        rbank_q, rbank_d;

  logic w_clr, w_adv, w_last;
  logic r_clr, r_adv, r_last;
  logic fin_w, wp_eff, push_acc, consume;

  raster_ctr #(.LAST_IDX(LAST_IDX)) u_wctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .adv_i  (w_adv),
    .x_o    (wx),
    .y_o    (wy),
    .last_o (w_last)
  );

  raster_ctr #(.LAST_IDX(LAST_IDX)) u_rctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (r_clr),
    .adv_i  (r_adv),
    .x_o    (rx),
    .y_o    (ry),
    .last_o (r_last)
  );

  // A frame's last write is on the output this cycle, so the writer already
  // targets the other bank; stopin looks at that bank to keep back-to-back frames safe.
  always_comb begin
    fin_w    = wr_q & w_last;
    wp_eff   = wp_q ^ fin_w;
    stopin   = bank_busy(bank_q[wp_eff]);
    push_acc = pushin & ~stopin;
    consume  = po_q & ~stopout;
  end

  // Next-state for bank states, pointers, writer and reader outputs.
  always_comb begin
    bank_d  = bank_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    wr_d    = 1'b0;
    wbank_d = wbank_q;
    w_clr   = 1'b0;
    w_adv   = 1'b0;
    po_d    = po_q;
    fo_d    = fo_q;
    rbank_d = rbank_q;
    r_clr   = 1'b0;
    r_adv   = 1'b0;

    // Writer: close the completed frame, then handle this cycle's push.
    if (fin_w) begin
      bank_d[wp_q] = BANK_FULL;
      wp_d         = ~wp_q;
    end
    if (push_acc) begin
      if (firstin) begin
        wr_d           = 1'b1;
        wbank_d        = wp_eff;
        w_clr          = 1'b1;
        bank_d[wp_eff] = BANK_FILLING;
      end else if (!fin_w && (bank_q[wp_q] == BANK_FILLING)) begin
        wr_d  = 1'b1;
        w_adv = 1'b1;
      end
    end

    // Reader: start on a full bank, advance on consume, chain to the other bank.
    if (!po_q) begin
      if (bank_q[rp_q] == BANK_FULL) begin
        po_d         = 1'b1;
        fo_d         = 1'b1;
        rbank_d      = rp_q;
        r_clr        = 1'b1;
        bank_d[rp_q] = BANK_DRAINING;
      end
    end else if (consume) begin
      if (r_last) begin
        bank_d[rp_q] = BANK_EMPTY;
        rp_d         = ~rp_q;
        if (bank_q[~rp_q] == BANK_FULL) begin
          po_d          = 1'b1;
          fo_d          = 1'b1;
          rbank_d       = ~rp_q;
          r_clr         = 1'b1;
          bank_d[~rp_q] = BANK_DRAINING;
        end else begin
          po_d = 1'b0;
          fo_d = 1'b0;
        end
      end else begin
        r_adv = 1'b1;
        fo_d  = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      wr_q      <= 1'b0;
      wbank_q   <= 1'b0;
      wd_q      <= '0;
      po_q      <= 1'b0;
      fo_q      <= 1'b0;
      rbank_q   <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      wr_q      <= wr_d;
      wbank_q   <= wbank_d;
      wd_q      <= din;
      po_q      <= po_d;
      fo_q      <= fo_d;
      rbank_q   <= rbank_d;
    end
  end

  assign wr       = wr_q;
  assign wbank    = wbank_q;
  assign wd       = wd_q;
  assign pushout  = po_q;
  assign firstout = fo_q;
  assign rbank    = rbank_q;

endmodule
